// File: rtl/imem_loader_pkg.sv
// loader_pkg: state encoding and frame sync byte shared by the imem loader files
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/imem_loader_rx_timeout.sv
// rx_timeout: inter-byte gap counter (clear, enable in; expired out when the gap would reach TIMEOUT-1)
module rx_timeout #(
  parameter int TIMEOUT = 1_000_000,
  parameter int TO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clear || !enable) ? '0 : cnt + TO_W'(1);
  assign expired = enable && !clear && cnt == TO_W'(TIMEOUT - 2);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: UART frame -> imem word writes, then releases cpu_hold and maps pc onto im_addr
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TIMEOUT = 1_000_000,
  parameter int TO_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              reload,
  input  logic [31:0]       pc,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_we,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  state_t state, nx;
  logic [15:0] len, n;
  logic [1:0] lane;
  logic [23:0] word;
  logic [7:0] chk;
  logic tmo, take, bad_len, last_word, unused;
  assign unused = ^{pc[31:ADDR_W+2], pc[1:0]};
  assign take = rx_valid && !reload;
  assign n = {rx_data, len[7:0]};
  assign bad_len = n == '0 || {1'b0, n} > (17'd1 << ADDR_W);
  // words_loaded has already absorbed the previous word's write by the time the next word completes
  assign last_word = lane == 2'd3 && len == 16'(words_loaded) + 16'd1;
  assign im_addr = im_we ? words_loaded[ADDR_W-1:0] : state == DONE ? pc[ADDR_W+1:2] : '0;
  rx_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .clk(clk), .rst(rst), .clear(rx_valid), .enable(busy), .expired(tmo)
  );
  always_comb begin
    nx = state;
    if (reload) nx = IDLE;
    else if (tmo) nx = ERR;
    else if (rx_valid)
      case (state)
        IDLE:    nx = rx_data == SYNC_BYTE ? LEN : IDLE;
        LEN:     nx = !lane[0] ? LEN : bad_len ? ERR : DATA;
        DATA:    nx = last_word ? CHK : DATA;
        CHK:     nx = rx_data == chk ? DONE : ERR;
        default: nx = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cpu_hold <= 1'b1;
      busy <= 1'b0;
      err <= 1'b0;
      im_we <= 1'b0;
      im_wdata <= '0;
      words_loaded <= '0;
      len <= '0;
      lane <= '0;
      word <= '0;
      chk <= '0;
    end else begin
      state <= nx;
      cpu_hold <= nx != DONE;
      busy <= nx inside {LEN, DATA, CHK};
      err <= nx == ERR;
      im_we <= take && state == DATA && lane == 2'd3;
      if (im_we) words_loaded <= words_loaded + 1'b1;
      if (take && state == IDLE && rx_data == SYNC_BYTE) begin
        chk <= '0;
        lane <= '0;
        words_loaded <= '0;
      end
      if (take && state == LEN) begin
        chk <= chk ^ rx_data;
        lane <= {1'b0, ~lane[0]};
        len <= lane[0] ? n : {8'h00, rx_data};
      end
      if (take && state == DATA) begin
        chk <= chk ^ rx_data;
        lane <= lane + 2'd1;
        word <= {lane == 2'd2 ? rx_data : word[23:16],
                 lane == 2'd1 ? rx_data : word[15:8],
                 lane == 2'd0 ? rx_data : word[7:0]};
        if (lane == 2'd3) im_wdata <= {rx_data, word};
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a byte-queue reference model plus directed literal checks
module tb_imem_loader;
  localparam int AW = 2;
  localparam int TMO = 16;
  localparam int CAP = 1 << AW;
  typedef logic [7:0] bq_t[$];

  logic clk = 0, rst = 1, rx_valid = 0, reload = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] pc = 0;
  logic [AW-1:0] im_addr;
  logic im_we, cpu_hold, busy, err;
  logic [31:0] im_wdata;
  logic [AW:0] words_loaded;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TMO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .reload(reload), .pc(pc),
    .im_addr(im_addr), .im_we(im_we), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: st 0 = waiting for sync, 1 = inside frame, 2 = loaded, 3 = error
  int st = 0, nlen = 0, gap = 0, wl = 0;
  bq_t fq;
  logic m_we = 0;
  logic [AW-1:0] m_addr = 0;
  logic [31:0] m_wdata = 0;

  task automatic model_byte(logic [7:0] b);
    int n;
    logic [7:0] x;
    fq.push_back(b);
    n = fq.size();
    if (n == 2) begin
      nlen = {fq[1], fq[0]};
      if (nlen == 0 || nlen > CAP) st = 3;
    end else if (n > 2 && n <= 2 + 4 * nlen) begin
      if ((n - 2) % 4 == 0) begin
        m_we = 1;
        m_addr = AW'((n - 2) / 4 - 1);
        m_wdata = {fq[n-1], fq[n-2], fq[n-3], fq[n-4]};
      end
    end else if (n > 2) begin
      x = 0;
      for (int i = 0; i < n - 1; i++) x ^= fq[i];
      st = (x == fq[n-1]) ? 2 : 3;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      st = 0; fq.delete(); gap = 0; wl = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    end else begin
      if (m_we) wl++;
      m_we = 0;
      if (reload) st = 0;
      else if (st == 1 && !rx_valid) begin
        gap++;
        if (gap == TMO - 1) st = 3;
      end else if (rx_valid) begin
        gap = 0;
        if (st == 0 && rx_data == 8'hA5) begin
          st = 1; fq.delete(); wl = 0;
        end else if (st == 1) model_byte(rx_data);
      end
    end
  end

  int we_cnt = 0;
  logic [31:0] dmem[CAP] = '{default: 0};
  always @(negedge clk) begin
    check("busy", busy, st == 1);
    check("err", err, st == 3);
    check("cpu_hold", cpu_hold, st != 2);
    check("im_we", im_we, m_we);
    check("im_addr", im_addr, m_we ? 32'(m_addr) : st == 2 ? 32'(pc[AW+1:2]) : 32'd0);
    check("im_wdata", im_wdata, m_wdata);
    check("words_loaded", words_loaded, wl);
    if (im_we === 1'b1) begin
      we_cnt++;
      dmem[im_addr] = im_wdata;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(logic [7:0] b);
    rx_valid = 1; rx_data = b; tick(); rx_valid = 0;
  endtask
  task automatic send_q(bq_t q, int maxgap);
    foreach (q[i]) begin
      send(q[i]);
      if (maxgap > 0) tick($urandom_range(0, maxgap));
    end
  endtask
  task automatic do_reload();
    reload = 1; tick(); reload = 0;
  endtask

  function automatic bq_t mk(int n, int nw, bit bad);
    bq_t q;
    logic [7:0] x;
    logic [31:0] w;
    q = '{8'hA5, n[7:0], n[15:8]};
    x = n[7:0] ^ n[15:8];
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) begin
        q.push_back(w[8*j +: 8]);
        x ^= w[8*j +: 8];
      end
    end
    q.push_back(bad ? ~x : x);
    return q;
  endfunction

  bq_t q, q2;
  int w0, r, k;

  initial begin
    #1 rst = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_words", words_loaded, 0);
    check("rst_wdata", im_wdata, 0);
    rst = 1;
    tick(2);
    pc = 32'h4;
    q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    send_q(q, 0);
    tick(2);
    check("load_w0", dmem[0], 32'h12345678);
    check("load_w1", dmem[1], 32'hDEADBEEF);
    check("load_cnt", words_loaded, 2);
    check("load_hold", cpu_hold, 0);
    check("load_err", err, 0);
    check("load_addr", im_addr, 1);
    check("load_we_cnt", we_cnt, 2);
    do_reload();
    check("reload_hold", cpu_hold, 1);
    check("reload_err", err, 0);
    check("reload_words_held", words_loaded, 2);
    send_q(q, 3);
    tick(2);
    check("reload_again_hold", cpu_hold, 0);
    do_reload();
    q2 = q;
    q2[11] = 8'h29;
    send_q(q2, 0);
    tick();
    check("badchk_err", err, 1);
    check("badchk_hold", cpu_hold, 1);
    w0 = we_cnt;
    send_q(q, 0);
    tick();
    check("err_sticky", err, 1);
    check("err_ignore_we", we_cnt, w0);
    do_reload();
    check("err_reload", err, 0);
    w0 = we_cnt;
    send_q('{8'hA5, 8'h00, 8'h00}, 0);
    tick();
    check("len0_err", err, 1);
    check("len0_no_we", we_cnt, w0);
    do_reload();
    send_q('{8'hA5, 8'h05, 8'h00}, 0);
    tick();
    check("len5_err", err, 1);
    do_reload();
    send_q(mk(4, 4, 0), 1);
    tick(2);
    check("len4_hold", cpu_hold, 0);
    check("len4_cnt", words_loaded, 4);
    do_reload();
    w0 = we_cnt;
    send_q('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56}, 0);
    tick(14);
    check("tmo_not_yet", err, 0);
    tick();
    check("tmo_err", err, 1);
    check("tmo_no_we", we_cnt, w0);
    tick(5);
    do_reload();
    reload = 1; rx_valid = 1; rx_data = 8'hA5;
    tick();
    reload = 0; rx_valid = 0;
    send(8'h02);
    check("reload_drop", busy, 0);
    send_q('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34}, 0);
    #2 rst = 0;
    #1;
    check("midrst_hold", cpu_hold, 1);
    check("midrst_busy", busy, 0);
    check("midrst_words", words_loaded, 0);
    check("midrst_wdata", im_wdata, 0);
    tick();
    rst = 1;
    tick();
    for (int it = 0; it < 40; it++) begin
      pc = $urandom;
      r = $urandom_range(0, 5);
      k = $urandom_range(1, CAP);
      case (r)
        0, 1: send_q(mk(k, k, 0), $urandom_range(0, 3));
        2: send_q(mk(k, k, 1), $urandom_range(0, 2));
        3: send_q(mk($urandom_range(0, 1) ? 0 : CAP + $urandom_range(1, 3), 0, 0), 1);
        4: repeat (3) send(8'($urandom));
        default: begin
          q = mk(k, k, 0);
          for (int i = 0, n = $urandom_range(1, q.size() - 1); i < n; i++) send(q[i]);
          tick(20);
        end
      endcase
      tick($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        rx_valid = 1; rx_data = 8'($urandom);
      end
      do_reload();
      rx_valid = 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
